// File: rtl/dla_axi_lite_pkg.sv
// Shared definitions for the DLA AXI-Lite manager: FSM state encodings,
// fixed AW/AR protection value, write-strobe fill bit and response codes.
// Imported by the manager RTL and by anything that needs the resp codes.
package dla_axi_lite_pkg;

  typedef enum logic [1:0] {
    W_IDLE      = 2'd0,
    W_ADDR_DATA = 2'd1,
    W_RESP      = 2'd2
  } wr_state_e;

  typedef enum logic [1:0] {
    R_IDLE = 2'd0,
    R_ADDR = 2'd1,
    R_DATA = 2'd2
  } rd_state_e;

  // Unprivileged, secure, data access on every address beat.
  localparam logic [2:0] AXI_PROT     = 3'b000;
  // Every write is a full-word write; replicated to the strobe width.
  localparam logic       AXI_STRB_BIT = 1'b1;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_EXOKAY = 2'b01;
  localparam logic [1:0] RESP_SLVERR = 2'b10;
  localparam logic [1:0] RESP_DECERR = 2'b11;

endpackage

// File: rtl/axi_lite_if.sv
// AXI-Lite bundle carrying AW, W, B, AR and R channels.
// Ports: manager modport drives addr/data/valids and the B/R readies;
// subordinate modport is the mirror image.
interface axi_lite_if #(
  parameter int ADDR_WIDTH = 16,
  parameter int DATA_WIDTH = 32
);
  logic [ADDR_WIDTH-1:0]   aw_addr;
  logic [2:0]              aw_prot;
  logic                    aw_valid;
  logic                    aw_ready;

  logic [DATA_WIDTH-1:0]   w_data;
  logic [DATA_WIDTH/8-1:0] w_strb;
  logic                    w_valid;
  logic                    w_ready;

  logic [1:0]              b_resp;
  logic                    b_valid;
  logic                    b_ready;

  logic [ADDR_WIDTH-1:0]   ar_addr;
  logic [2:0]              ar_prot;
  logic                    ar_valid;
  logic                    ar_ready;

  logic [DATA_WIDTH-1:0]   r_data;
  logic [1:0]              r_resp;
  logic                    r_valid;
  logic                    r_ready;

  modport manager (
    output aw_addr, aw_prot, aw_valid, input aw_ready,
    output w_data, w_strb, w_valid,    input w_ready,
    input  b_resp, b_valid,            output b_ready,
    output ar_addr, ar_prot, ar_valid, input ar_ready,
    input  r_data, r_resp, r_valid,    output r_ready
  );

  modport subordinate (
    input  aw_addr, aw_prot, aw_valid, output aw_ready,
    input  w_data, w_strb, w_valid,    output w_ready,
    output b_resp, b_valid,            input b_ready,
    input  ar_addr, ar_prot, ar_valid, output ar_ready,
    output r_data, r_resp, r_valid,    input r_ready
  );
endinterface

// File: rtl/dla_axi_lite_m.sv
// AXI-Lite manager turning level requests into single AXI-Lite write/read transactions.
// Ports: clk_i/rst_i (sync, active-high), req_i {rd,wr}, write/read address, write data,
//        rsp_o {rd_done,wr_done} one-cycle pulses, dla_data_o registered read data, pp_if manager.
module dla_axi_lite_m
  import dla_axi_lite_pkg::*;
#(
  parameter int AXI_ADDR_WIDTH = 16,
  parameter int AXI_DATA_WIDTH = 32
) (
  input  logic                      clk_i,
  input  logic                      rst_i,
  input  logic [1:0]                req_i,
  input  logic [AXI_ADDR_WIDTH-1:0] axi_wr_addr_i,
  input  logic [AXI_ADDR_WIDTH-1:0] axi_rd_addr_i,
  input  logic [AXI_DATA_WIDTH-1:0] pp_data_i,
  output logic [1:0]                rsp_o,
  output logic [AXI_DATA_WIDTH-1:0] dla_data_o,
  axi_lite_if.manager               pp_if
);

  // ---------------- write path state ----------------
  wr_state_e                 wr_state;
  logic [AXI_ADDR_WIDTH-1:0] wr_addr_q;
  logic [AXI_DATA_WIDTH-1:0] wr_data_q;
  logic                      aw_valid_q;
  logic                      w_valid_q;
  logic                      b_ready_q;
  logic                      wr_done_q;

  // ---------------- read path state -----------------
  rd_state_e                 rd_state;
  logic [AXI_ADDR_WIDTH-1:0] rd_addr_q;
  logic [AXI_DATA_WIDTH-1:0] rd_data_q;
  logic                      ar_valid_q;
  logic                      r_ready_q;
  logic                      rd_done_q;

  // A channel is still owed a handshake if it is valid and not accepted this cycle.
  logic aw_owed;
  logic w_owed;
  assign aw_owed = aw_valid_q & ~pp_if.aw_ready;
  assign w_owed  = w_valid_q  & ~pp_if.w_ready;

  // ---------------- write FSM ----------------
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      wr_state   <= W_IDLE;
      wr_addr_q  <= '0;
      wr_data_q  <= '0;
      aw_valid_q <= 1'b0;
      w_valid_q  <= 1'b0;
      b_ready_q  <= 1'b0;
      wr_done_q  <= 1'b0;
    end else begin
      wr_done_q <= 1'b0;
      case (wr_state)
        W_IDLE: begin
          if (req_i[0]) begin
            wr_addr_q  <= axi_wr_addr_i;
            wr_data_q  <= pp_data_i;
            aw_valid_q <= 1'b1;
            w_valid_q  <= 1'b1;
            wr_state   <= W_ADDR_DATA;
          end
        end
        W_ADDR_DATA: begin
          // AW and W retire independently, in either order or together.
          if (aw_valid_q && pp_if.aw_ready) aw_valid_q <= 1'b0;
          if (w_valid_q  && pp_if.w_ready)  w_valid_q  <= 1'b0;
          if (!aw_owed && !w_owed) begin
            b_ready_q <= 1'b1;
            wr_state  <= W_RESP;
          end
        end
        W_RESP: begin
          // Any b_resp code ends the transaction; errors are not retried.
          if (pp_if.b_valid) begin
            b_ready_q <= 1'b0;
            wr_done_q <= 1'b1;
            wr_state  <= W_IDLE;
          end
        end
        default: begin
          aw_valid_q <= 1'b0;
          w_valid_q  <= 1'b0;
          b_ready_q  <= 1'b0;
          wr_state   <= W_IDLE;
        end
      endcase
    end
  end

  // ---------------- read FSM ----------------
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      rd_state   <= R_IDLE;
      rd_addr_q  <= '0;
      rd_data_q  <= '0;
      ar_valid_q <= 1'b0;
      r_ready_q  <= 1'b0;
      rd_done_q  <= 1'b0;
    end else begin
      rd_done_q <= 1'b0;
      case (rd_state)
        R_IDLE: begin
          if (req_i[1]) begin
            rd_addr_q  <= axi_rd_addr_i;
            ar_valid_q <= 1'b1;
            rd_state   <= R_ADDR;
          end
        end
        R_ADDR: begin
          if (pp_if.ar_ready) begin
            ar_valid_q <= 1'b0;
            r_ready_q  <= 1'b1;
            rd_state   <= R_DATA;
          end
        end
        R_DATA: begin
          // Data is captured whatever r_resp says.
          if (pp_if.r_valid) begin
            rd_data_q <= pp_if.r_data;
            r_ready_q <= 1'b0;
            rd_done_q <= 1'b1;
            rd_state  <= R_IDLE;
          end
        end
        default: begin
          ar_valid_q <= 1'b0;
          r_ready_q  <= 1'b0;
          rd_state   <= R_IDLE;
        end
      endcase
    end
  end

  // ---------------- outputs ----------------
  assign pp_if.aw_addr  = wr_addr_q;
  assign pp_if.aw_prot  = AXI_PROT;
  assign pp_if.aw_valid = aw_valid_q;
  assign pp_if.w_data   = wr_data_q;
  assign pp_if.w_strb   = {(AXI_DATA_WIDTH/8){AXI_STRB_BIT}};
  assign pp_if.w_valid  = w_valid_q;
  assign pp_if.b_ready  = b_ready_q;
  assign pp_if.ar_addr  = rd_addr_q;
  assign pp_if.ar_prot  = AXI_PROT;
  assign pp_if.ar_valid = ar_valid_q;
  assign pp_if.r_ready  = r_ready_q;

  assign rsp_o      = {rd_done_q, wr_done_q};
  assign dla_data_o = rd_data_q;

endmodule

// File: tb/tb_dla_axi_lite_m.sv
module tb_dla_axi_lite_m;
  import dla_axi_lite_pkg::*;

  logic        clk;
  logic        rst;
  logic [1:0]  req;
  logic [15:0] wr_addr;
  logic [15:0] rd_addr;
  logic [31:0] wdata;
  logic [1:0]  rsp;
  logic [31:0] dla_data;

  axi_lite_if #(.ADDR_WIDTH(16), .DATA_WIDTH(32)) axi ();

  dla_axi_lite_m #(.AXI_ADDR_WIDTH(16), .AXI_DATA_WIDTH(32)) dut (
    .clk_i        (clk),
    .rst_i        (rst),
    .req_i        (req),
    .axi_wr_addr_i(wr_addr),
    .axi_rd_addr_i(rd_addr),
    .pp_data_i    (wdata),
    .rsp_o        (rsp),
    .dla_data_o   (dla_data),
    .pp_if        (axi)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- subordinate model ----------------
  bit          rand_mode;
  int          cfg_aw, cfg_w, cfg_b, cfg_ar, cfg_r;
  int          rnd_aw, rnd_w, rnd_b, rnd_ar, rnd_r;
  logic [1:0]  cfg_bresp, cfg_rresp;
  logic [31:0] cfg_rdata, rnd_rdata;

  int aw_tot, w_tot, b_tot, ar_tot, r_tot;
  int aw_wait, w_wait, b_wait, ar_wait, r_wait;

  // Cumulative monitor counters (never cleared; the sequence works on deltas).
  int aw_hs, w_hs, b_hs, ar_hs, r_hs;
  int rsp_wr_cnt, rsp_rd_cnt;
  int awv_cyc, wv_cyc;
  int viol, bad_addr;
  logic [15:0] last_aw_addr, last_ar_addr;
  logic [31:0] last_w_data, last_r_data;
  logic [3:0]  last_w_strb;
  logic [2:0]  last_aw_prot, last_ar_prot;

  logic        prev_awv, prev_aw_hs, prev_wv, prev_w_hs, prev_arv, prev_ar_hs;
  logic [15:0] prev_aw_addr, prev_ar_addr;
  logic [31:0] prev_w_data;

  int eff_aw, eff_w, eff_b, eff_ar, eff_r;
  assign eff_aw = rand_mode ? rnd_aw : cfg_aw;
  assign eff_w  = rand_mode ? rnd_w  : cfg_w;
  assign eff_b  = rand_mode ? rnd_b  : cfg_b;
  assign eff_ar = rand_mode ? rnd_ar : cfg_ar;
  assign eff_r  = rand_mode ? rnd_r  : cfg_r;

  logic b_pend, r_pend;
  assign b_pend = (aw_tot > b_tot) && (w_tot > b_tot);
  assign r_pend = (ar_tot > r_tot);

  assign axi.aw_ready = axi.aw_valid && (aw_wait >= eff_aw);
  assign axi.w_ready  = axi.w_valid  && (w_wait  >= eff_w);
  assign axi.b_valid  = b_pend && (b_wait >= eff_b);
  assign axi.b_resp   = cfg_bresp;
  assign axi.ar_ready = axi.ar_valid && (ar_wait >= eff_ar);
  assign axi.r_valid  = r_pend && (r_wait >= eff_r);
  assign axi.r_resp   = cfg_rresp;
  assign axi.r_data   = rand_mode ? rnd_rdata : cfg_rdata;

  always @(posedge clk) begin
    if (rst) begin
      aw_tot <= 0; w_tot <= 0; b_tot <= 0; ar_tot <= 0; r_tot <= 0;
      aw_wait <= 0; w_wait <= 0; b_wait <= 0; ar_wait <= 0; r_wait <= 0;
      prev_awv <= 1'b0; prev_wv <= 1'b0; prev_arv <= 1'b0;
    end else begin
      if (axi.aw_valid && axi.aw_ready) begin
        aw_tot <= aw_tot + 1; aw_wait <= 0; aw_hs <= aw_hs + 1;
        last_aw_addr <= axi.aw_addr; last_aw_prot <= axi.aw_prot;
        rnd_aw <= $urandom_range(0, 3);
        if (rand_mode && axi.aw_addr != 16'h5000) bad_addr <= bad_addr + 1;
      end else if (axi.aw_valid) aw_wait <= aw_wait + 1;

      if (axi.w_valid && axi.w_ready) begin
        w_tot <= w_tot + 1; w_wait <= 0; w_hs <= w_hs + 1;
        last_w_data <= axi.w_data; last_w_strb <= axi.w_strb;
        rnd_w <= $urandom_range(0, 3);
      end else if (axi.w_valid) w_wait <= w_wait + 1;

      if (axi.b_valid && axi.b_ready) begin
        b_tot <= b_tot + 1; b_wait <= 0; b_hs <= b_hs + 1;
        rnd_b <= $urandom_range(0, 3);
      end else if (b_pend) b_wait <= b_wait + 1;

      if (axi.ar_valid && axi.ar_ready) begin
        ar_tot <= ar_tot + 1; ar_wait <= 0; ar_hs <= ar_hs + 1;
        last_ar_addr <= axi.ar_addr; last_ar_prot <= axi.ar_prot;
        rnd_ar <= $urandom_range(0, 3);
        if (rand_mode && axi.ar_addr != 16'h6000) bad_addr <= bad_addr + 1;
      end else if (axi.ar_valid) ar_wait <= ar_wait + 1;

      if (axi.r_valid && axi.r_ready) begin
        r_tot <= r_tot + 1; r_wait <= 0; r_hs <= r_hs + 1;
        last_r_data <= axi.r_data;
        rnd_r <= $urandom_range(0, 3);
        rnd_rdata <= $urandom;
      end else if (r_pend) r_wait <= r_wait + 1;

      // Once raised, a valid must hold with stable payload until accepted.
      if (prev_awv && !prev_aw_hs && (!axi.aw_valid || axi.aw_addr != prev_aw_addr)) viol <= viol + 1;
      if (prev_wv  && !prev_w_hs  && (!axi.w_valid  || axi.w_data  != prev_w_data))  viol <= viol + 1;
      if (prev_arv && !prev_ar_hs && (!axi.ar_valid || axi.ar_addr != prev_ar_addr)) viol <= viol + 1;
      prev_awv <= axi.aw_valid; prev_aw_hs <= axi.aw_valid && axi.aw_ready; prev_aw_addr <= axi.aw_addr;
      prev_wv  <= axi.w_valid;  prev_w_hs  <= axi.w_valid  && axi.w_ready;  prev_w_data  <= axi.w_data;
      prev_arv <= axi.ar_valid; prev_ar_hs <= axi.ar_valid && axi.ar_ready; prev_ar_addr <= axi.ar_addr;

      if (rsp[0]) rsp_wr_cnt <= rsp_wr_cnt + 1;
      if (rsp[1]) rsp_rd_cnt <= rsp_rd_cnt + 1;
      if (axi.aw_valid) awv_cyc <= awv_cyc + 1;
      if (axi.w_valid)  wv_cyc  <= wv_cyc + 1;
    end
  end

  // ---------------- checking ----------------
  int n_cmp = 0;
  int n_err = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  function automatic logic [5:0] ctl_bits();
    return {axi.aw_valid, axi.w_valid, axi.b_ready, axi.ar_valid, axi.r_ready, 1'b0};
  endfunction

  typedef struct {
    logic [1:0]  req;
    logic [15:0] wr_addr;
    logic [15:0] rd_addr;
    logic [31:0] wdata;
    logic [31:0] rdata;
    logic [1:0]  bresp;
    logic [1:0]  rresp;
    int          aw_dly, w_dly, b_dly, ar_dly, r_dly;
    logic [15:0] exp_aw;
    logic [31:0] exp_w;
    logic [15:0] exp_ar;
    logic [31:0] exp_dla;
  } vec_t;

  vec_t vecs[6];

  initial begin
    int base_wr, base_rd, base_b, base_r, base_v, base_awc, base_wc, base_bad;
    int cyc;

    vecs[0] = '{2'b01, 16'h5000, 16'h0000, 32'hDEADBEEF, 32'h0, RESP_OKAY, RESP_OKAY,
                0, 0, 0, 0, 0, 16'h5000, 32'hDEADBEEF, 16'h0000, 32'h00000000};
    vecs[1] = '{2'b10, 16'h0000, 16'h6000, 32'h0, 32'h12345678, RESP_OKAY, RESP_OKAY,
                0, 0, 0, 0, 0, 16'h0000, 32'h0, 16'h6000, 32'h12345678};
    vecs[2] = '{2'b01, 16'h1234, 16'h0000, 32'hCAFEF00D, 32'h0, RESP_SLVERR, RESP_OKAY,
                0, 3, 2, 0, 0, 16'h1234, 32'hCAFEF00D, 16'h0000, 32'h12345678};
    vecs[3] = '{2'b01, 16'h00FC, 16'h0000, 32'hA5A55A5A, 32'h0, RESP_OKAY, RESP_OKAY,
                3, 0, 0, 0, 0, 16'h00FC, 32'hA5A55A5A, 16'h0000, 32'h12345678};
    vecs[4] = '{2'b10, 16'h0000, 16'hFFFC, 32'h0, 32'hBAD0BAD0, RESP_OKAY, RESP_SLVERR,
                0, 0, 0, 2, 4, 16'h0000, 32'h0, 16'hFFFC, 32'hBAD0BAD0};
    vecs[5] = '{2'b11, 16'h5000, 16'h6000, 32'h11112222, 32'h33334444, RESP_OKAY, RESP_OKAY,
                1, 2, 1, 1, 1, 16'h5000, 32'h11112222, 16'h6000, 32'h33334444};

    rand_mode = 1'b0;
    cfg_aw = 0; cfg_w = 0; cfg_b = 0; cfg_ar = 0; cfg_r = 0;
    rnd_aw = 0; rnd_w = 0; rnd_b = 0; rnd_ar = 0; rnd_r = 0;
    cfg_bresp = RESP_OKAY; cfg_rresp = RESP_OKAY; cfg_rdata = '0; rnd_rdata = 32'h0BADF00D;
    aw_hs = 0; w_hs = 0; b_hs = 0; ar_hs = 0; r_hs = 0;
    rsp_wr_cnt = 0; rsp_rd_cnt = 0; awv_cyc = 0; wv_cyc = 0; viol = 0; bad_addr = 0;
    rst = 1'b1; req = 2'b11; wr_addr = 16'h5000; rd_addr = 16'h6000; wdata = 32'hFFFFFFFF;

    // Reset with requests held high: they must be ignored.
    repeat (3) @(negedge clk);
    chk("reset_ctl", 64'(ctl_bits()), 64'h0);
    chk("reset_rsp", 64'(rsp), 64'h0);
    chk("reset_dla", 64'(dla_data), 64'h0);
    chk("reset_aw_addr", 64'(axi.aw_addr), 64'h0);
    chk("reset_w_data", 64'(axi.w_data), 64'h0);
    req = 2'b00;
    rst = 1'b0;
    @(negedge clk);

    // ---------------- directed vectors ----------------
    for (int i = 0; i < 6; i++) begin
      cfg_aw = vecs[i].aw_dly; cfg_w = vecs[i].w_dly; cfg_b = vecs[i].b_dly;
      cfg_ar = vecs[i].ar_dly; cfg_r = vecs[i].r_dly;
      cfg_bresp = vecs[i].bresp; cfg_rresp = vecs[i].rresp; cfg_rdata = vecs[i].rdata;
      wr_addr = vecs[i].wr_addr; rd_addr = vecs[i].rd_addr; wdata = vecs[i].wdata;
      base_wr = rsp_wr_cnt; base_rd = rsp_rd_cnt; base_b = b_hs; base_r = r_hs;
      req = vecs[i].req;
      @(negedge clk);
      req = 2'b00;
      cyc = 0;
      while (cyc < 60 && !((rsp_wr_cnt - base_wr) >= int'(vecs[i].req[0]) &&
                           (rsp_rd_cnt - base_rd) >= int'(vecs[i].req[1]))) begin
        @(negedge clk);
        cyc++;
      end
      repeat (3) @(negedge clk);
      if (vecs[i].req[0]) begin
        chk($sformatf("v%0d_aw_addr", i), 64'(last_aw_addr), 64'(vecs[i].exp_aw));
        chk($sformatf("v%0d_w_data", i), 64'(last_w_data), 64'(vecs[i].exp_w));
        chk($sformatf("v%0d_w_strb", i), 64'(last_w_strb), 64'hF);
        chk($sformatf("v%0d_aw_prot", i), 64'(last_aw_prot), 64'h0);
        chk($sformatf("v%0d_b_accepts", i), 64'(b_hs - base_b), 64'd1);
      end
      if (vecs[i].req[1]) begin
        chk($sformatf("v%0d_ar_addr", i), 64'(last_ar_addr), 64'(vecs[i].exp_ar));
        chk($sformatf("v%0d_ar_prot", i), 64'(last_ar_prot), 64'h0);
        chk($sformatf("v%0d_r_accepts", i), 64'(r_hs - base_r), 64'd1);
      end
      chk($sformatf("v%0d_rsp_wr_pulses", i), 64'(rsp_wr_cnt - base_wr), 64'(vecs[i].req[0]));
      chk($sformatf("v%0d_rsp_rd_pulses", i), 64'(rsp_rd_cnt - base_rd), 64'(vecs[i].req[1]));
      chk($sformatf("v%0d_dla_data", i), 64'(dla_data), 64'(vecs[i].exp_dla));
      chk($sformatf("v%0d_idle", i), 64'(ctl_bits()), 64'h0);
    end

    // ---------------- AW stalled 5 cycles, W immediate ----------------
    cfg_aw = 5; cfg_w = 0; cfg_b = 0; cfg_bresp = RESP_OKAY;
    wr_addr = 16'h5000; wdata = 32'h0F0F0F0F;
    base_wr = rsp_wr_cnt; base_b = b_hs; base_v = viol; base_awc = awv_cyc; base_wc = wv_cyc;
    req = 2'b01;
    @(negedge clk);
    req = 2'b00;
    cyc = 0;
    while (cyc < 40 && (rsp_wr_cnt - base_wr) < 1) begin
      @(negedge clk);
      cyc++;
    end
    repeat (3) @(negedge clk);
    chk("stall_aw_valid_cycles", 64'(awv_cyc - base_awc), 64'd6);
    chk("stall_w_valid_cycles", 64'(wv_cyc - base_wc), 64'd1);
    chk("stall_b_accepts", 64'(b_hs - base_b), 64'd1);
    chk("stall_rsp_wr_pulses", 64'(rsp_wr_cnt - base_wr), 64'd1);
    chk("stall_protocol", 64'(viol - base_v), 64'd0);
    chk("stall_aw_addr", 64'(last_aw_addr), 64'h5000);

    // ---------------- continuous concurrent traffic, random delays ----------------
    wr_addr = 16'h5000; rd_addr = 16'h6000; wdata = 32'h77778888;
    rnd_aw = 2; rnd_w = 0; rnd_b = 1; rnd_ar = 3; rnd_r = 1;
    rand_mode = 1'b1;
    base_wr = rsp_wr_cnt; base_rd = rsp_rd_cnt; base_b = b_hs; base_r = r_hs;
    base_v = viol; base_bad = bad_addr;
    req = 2'b11;
    repeat (300) @(negedge clk);
    req = 2'b00;
    cyc = 0;
    while (cyc < 100 && ctl_bits() != 6'h0) begin
      @(negedge clk);
      cyc++;
    end
    repeat (3) @(negedge clk);
    chk("conc_drained", 64'(ctl_bits()), 64'h0);
    chk("conc_wr_pulse_per_b", 64'(rsp_wr_cnt - base_wr), 64'(b_hs - base_b));
    chk("conc_rd_pulse_per_r", 64'(rsp_rd_cnt - base_rd), 64'(r_hs - base_r));
    chk("conc_many_writes", 64'((b_hs - base_b) >= 20), 64'd1);
    chk("conc_many_reads", 64'((r_hs - base_r) >= 20), 64'd1);
    chk("conc_protocol", 64'(viol - base_v), 64'd0);
    chk("conc_addresses", 64'(bad_addr - base_bad), 64'd0);
    chk("conc_last_rdata", 64'(dla_data), 64'(last_r_data));
    rand_mode = 1'b0;

    // ---------------- reset while waiting in R_DATA ----------------
    cfg_ar = 0; cfg_r = 40; cfg_rdata = 32'h55AA55AA; rd_addr = 16'h6000;
    req = 2'b10;
    @(negedge clk);
    req = 2'b00;
    cyc = 0;
    while (cyc < 20 && !axi.r_ready) begin
      @(negedge clk);
      cyc++;
    end
    chk("rst_reached_r_data", 64'(axi.r_ready), 64'd1);
    chk("rst_dla_nonzero_before", 64'(dla_data != 32'h0), 64'd1);
    rst = 1'b1;
    req = 2'b11;
    @(negedge clk);
    chk("midrst_ctl", 64'(ctl_bits()), 64'h0);
    chk("midrst_rsp", 64'(rsp), 64'h0);
    chk("midrst_dla", 64'(dla_data), 64'h0);
    @(negedge clk);
    chk("midrst_req_ignored", 64'(ctl_bits()), 64'h0);
    req = 2'b00;
    rst = 1'b0;
    repeat (3) @(negedge clk);
    chk("postrst_idle", 64'(ctl_bits()), 64'h0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
